// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the blocked matrix multiplier tile datapath:
//   - default tile geometry (DEF_BLOCK_SIZE x DEF_BLOCK_SIZE, DEF_DATA_WIDTH)
//   - index width helper, sized to hold BLOCK_SIZE so non-power-of-2
//     tiles never rely on natural counter overflow
//   - drain FSM state encoding
//   - packed-tile element offset helper
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam int DEF_BLOCK_SIZE = 3;
  localparam int DEF_DATA_WIDTH = 16;

  // Width of a row/column index for a given tile dimension.
  function automatic int idx_width(input int block_size);
    return $clog2(block_size + 1);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_BLOCK_SIZE);

  // Drain FSM state encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Bit offset of element (r,c) inside a row-major packed tile.
  function automatic int elem_offset(input int r, input int c,
                                     input int block_size, input int data_width);
    return (r * block_size + c) * data_width;
  endfunction

endpackage

// File: rtl/tile_index_counter.sv
// -----------------------------------------------------------------------------
// tile_index_counter
// Two-level row/column counter walking a BLOCK_SIZE x BLOCK_SIZE tile in
// row-major order. Shared by the load-side sequencer and the result drain.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset (indices -> 0)
//   clear_i    force indices to (0,0); wins over advance_i
//   advance_i  step to the next element
//   row_o      current row index
//   col_o      current column index
//   last_o     current element is (BLOCK_SIZE-1, BLOCK_SIZE-1)
//   wrap_o     advance on the last element this cycle (tile completes)
// -----------------------------------------------------------------------------
module tile_index_counter
  import matmul_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  localparam int IDX_W     = idx_width(BLOCK_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_o,
  output logic             wrap_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             col_end;
  logic             row_end;

  // Wrap is an explicit compare so BLOCK_SIZE need not be a power of two.
  assign col_end = (col_q == LAST_IDX);
  assign row_end = (row_q == LAST_IDX);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (!col_end) begin
        col_d = col_q + ONE;
      end else begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_end && row_end;
  assign wrap_o = advance_i && col_end && row_end;

endmodule

// File: rtl/tile_result_drain.sv
// -----------------------------------------------------------------------------
// tile_result_drain
// Captures one BLOCK_SIZE x BLOCK_SIZE result tile in a single parallel
// handshake and streams it out row-major, one element per beat, with row/col
// indices and a last flag. A new tile may be captured on the final beat of the
// current one, giving a gapless back-to-back stream.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   load_valid  producer offers a complete tile
//   load_ready  drain accepts a tile this cycle (IDLE, or final beat accepted)
//   load_data   packed tile, element (r,c) at elem_offset(r,c,...)
//   out_valid   out_data holds a valid element
//   out_ready   downstream accepts the element
//   out_data    current element
//   out_row     row index of out_data
//   out_col     column index of out_data
//   out_last    out_data is the final element of the tile
//   busy        high while draining
// -----------------------------------------------------------------------------
module tile_result_drain
  import matmul_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int IDX_W     = idx_width(BLOCK_SIZE),
  localparam int TILE_W    = BLOCK_SIZE * BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [TILE_W-1:0]     load_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_row,
  output logic [IDX_W-1:0]      out_col,
  output logic                  out_last,
  output logic                  busy
);

  logic [0:0]        state_q, state_d;
  logic [TILE_W-1:0] tile_q;
  logic              draining;
  logic              load_fire;
  logic              out_fire;
  logic              idx_last;
  logic              tile_wrap;
  logic [IDX_W-1:0]  row;
  logic [IDX_W-1:0]  col;
  logic [DATA_WIDTH-1:0] elems [BLOCK_SIZE][BLOCK_SIZE];

  assign draining  = (state_q == ST_DRAIN);
  assign out_fire  = draining && out_ready;
  // Only combinational input-to-output path: the final beat frees the slot.
  assign load_ready = !draining || (idx_last && out_ready);
  assign load_fire  = load_valid && load_ready;

  tile_index_counter #(
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (load_fire),
    .advance_i (out_fire),
    .row_o     (row),
    .col_o     (col),
    .last_o    (idx_last),
    .wrap_o    (tile_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (!draining) begin
      if (load_fire) state_d = ST_DRAIN;
    end else if (tile_wrap) begin
      // Final beat accepted: continue straight into a waiting tile.
      state_d = load_valid ? ST_DRAIN : ST_IDLE;
    end
  end

  // NOTE: the tile store is a bank of flops, not a RAM macro, so it is reset
  // along with the control state; out_data is defined to be zero from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_fire) tile_q <= load_data;
    end
  end

  // Constant-offset view of the packed tile for a clean 2-D mux.
  for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
    for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_col
      assign elems[r][c] =
        tile_q[elem_offset(r, c, BLOCK_SIZE, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  assign out_valid = draining;
  assign busy      = draining;
  assign out_data  = draining ? elems[row][col] : '0;
  assign out_row   = row;
  assign out_col   = col;
  assign out_last  = draining && idx_last;

endmodule

// File: tb/tb_tile_result_drain.sv
// -----------------------------------------------------------------------------
// tb_tile_result_drain
// Directed bench for tile_result_drain at BLOCK_SIZE 3, 5 and 2.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling
// edge. Element (r,c) of every tile is base + 16'h0100*r + c.
// -----------------------------------------------------------------------------
module tb_tile_result_drain;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // BLOCK_SIZE = 3
  logic         lv3 = 1'b0, lr3, ov3, ordy3 = 1'b0, olast3, busy3;
  logic [143:0] ld3 = '0;
  logic [15:0]  od3;
  logic [1:0]   orow3, ocol3;
  // BLOCK_SIZE = 5
  logic         lv5 = 1'b0, lr5, ov5, ordy5 = 1'b0, olast5, busy5;
  logic [399:0] ld5 = '0;
  logic [15:0]  od5;
  logic [2:0]   orow5, ocol5;
  // BLOCK_SIZE = 2
  logic         lv2 = 1'b0, lr2, ov2, ordy2 = 1'b0, olast2, busy2;
  logic [63:0]  ld2 = '0;
  logic [15:0]  od2;
  logic [1:0]   orow2, ocol2;

  tile_result_drain #(.BLOCK_SIZE(3), .DATA_WIDTH(16)) dut3 (
    .clk(clk), .rst(rst), .load_valid(lv3), .load_ready(lr3), .load_data(ld3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_row(orow3),
    .out_col(ocol3), .out_last(olast3), .busy(busy3));

  tile_result_drain #(.BLOCK_SIZE(5), .DATA_WIDTH(16)) dut5 (
    .clk(clk), .rst(rst), .load_valid(lv5), .load_ready(lr5), .load_data(ld5),
    .out_valid(ov5), .out_ready(ordy5), .out_data(od5), .out_row(orow5),
    .out_col(ocol5), .out_last(olast5), .busy(busy5));

  tile_result_drain #(.BLOCK_SIZE(2), .DATA_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2), .load_data(ld2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_row(orow2),
    .out_col(ocol2), .out_last(olast2), .busy(busy2));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        lv;    // load_valid driven this cycle
    logic        ordy;  // out_ready driven this cycle
    logic        ev;    // expected out_valid / busy
    logic [15:0] ed;    // expected out_data (when valid)
    int          er;    // expected out_row
    int          ec;    // expected out_col
    logic        el;    // expected out_last
    logic        elr;   // expected load_ready
  } vec_t;

  vec_t vecs[$];

  function automatic logic [399:0] mk_tile(input int bs, input logic [15:0] base);
    logic [399:0] t;
    t = '0;
    for (int r = 0; r < bs; r++)
      for (int c = 0; c < bs; c++)
        t[(r * bs + c) * 16 +: 16] = base + 16'(16'h0100 * r) + 16'(c);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic ev, input logic [15:0] ed,
                      input int er, input int ec, input logic el, input logic elr);
    check({tag, " valid"}, 32'(ov3), 32'(ev));
    check({tag, " busy"}, 32'(busy3), 32'(ev));
    if (ev) begin
      check({tag, " data"}, 32'(od3), 32'(ed));
      check({tag, " row"}, 32'(orow3), 32'(er));
      check({tag, " col"}, 32'(ocol3), 32'(ec));
    end
    check({tag, " last"}, 32'(olast3), 32'(el));
    check({tag, " load_ready"}, 32'(lr3), 32'(elr));
  endtask

  task automatic cyc3(input logic lv, input logic ordy);
    @(posedge clk);
    #1;
    lv3   = lv;
    ordy3 = ordy;
    @(negedge clk);
  endtask

  task automatic add(input logic lv, input logic ordy, input logic ev,
                     input logic [15:0] ed, input int er, input int ec,
                     input logic el, input logic elr);
    vec_t v;
    v.lv = lv; v.ordy = ordy; v.ev = ev; v.ed = ed;
    v.er = er; v.ec = ec; v.el = el; v.elr = elr;
    vecs.push_back(v);
  endtask

  initial begin
    logic [399:0] t;
    logic [143:0] tile_a, tile_b;
    int beats;

    t = mk_tile(3, 16'h0000); tile_a = t[143:0];
    t = mk_tile(3, 16'h1000); tile_b = t[143:0];

    // ---- basic drain: 9 beats, out_ready held high ----
    add(1, 1, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 1, 16'h0001, 0, 1, 0, 0);
    add(0, 1, 1, 16'h0002, 0, 2, 0, 0);
    add(0, 1, 1, 16'h0100, 1, 0, 0, 0);
    add(0, 1, 1, 16'h0101, 1, 1, 0, 0);
    add(0, 1, 1, 16'h0102, 1, 2, 0, 0);
    add(0, 1, 1, 16'h0200, 2, 0, 0, 0);
    add(0, 1, 1, 16'h0201, 2, 1, 0, 0);
    add(0, 1, 1, 16'h0202, 2, 2, 1, 1);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 1);
    // ---- backpressure: stall 4 cycles on (1,1) ----
    add(1, 1, 0, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 1, 16'h0001, 0, 1, 0, 0);
    add(0, 1, 1, 16'h0002, 0, 2, 0, 0);
    add(0, 1, 1, 16'h0100, 1, 0, 0, 0);
    add(0, 0, 1, 16'h0101, 1, 1, 0, 0);
    add(0, 0, 1, 16'h0101, 1, 1, 0, 0);
    add(0, 0, 1, 16'h0101, 1, 1, 0, 0);
    add(0, 0, 1, 16'h0101, 1, 1, 0, 0);
    add(0, 1, 1, 16'h0101, 1, 1, 0, 0);
    add(0, 1, 1, 16'h0102, 1, 2, 0, 0);
    add(0, 1, 1, 16'h0200, 2, 0, 0, 0);
    add(0, 1, 1, 16'h0201, 2, 1, 0, 0);
    add(0, 1, 1, 16'h0202, 2, 2, 1, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 1);

    // ---- reset state ----
    #2;
    chk3("reset", 0, 16'h0000, 0, 0, 0, 1);
    check("reset data3", 32'(od3), 32'h0);
    check("reset valid5", 32'(ov5), 32'h0);
    check("reset valid2", 32'(ov2), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ---- table-driven: basic drain + backpressure ----
    ld3 = tile_a;
    beats = 0;
    foreach (vecs[i]) begin
      cyc3(vecs[i].lv, vecs[i].ordy);
      if (ov3 && ordy3) beats++;
      chk3($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].er,
           vecs[i].ec, vecs[i].el, vecs[i].elr);
    end
    check("table accepted beats", 32'(beats), 32'd18);

    // ---- back-to-back: tile B offered on tile A's final beat ----
    ld3 = tile_a;
    cyc3(1, 1);
    chk3("b2b load", 0, 16'h0, 0, 0, 0, 1);
    beats = 0;
    for (int k = 0; k < 18; k++) begin
      int b;
      logic [15:0] base;
      b = k % 9;
      base = (k < 9) ? 16'h0000 : 16'h1000;
      if (k == 8) ld3 = tile_b;
      cyc3(k == 8, 1);
      if (ov3 && ordy3) beats++;
      chk3($sformatf("b2b beat%0d", k), 1, base + 16'(16'h0100 * (b / 3)) + 16'(b % 3),
           b / 3, b % 3, b == 8, b == 8);
    end
    check("b2b beats in 18 cycles", 32'(beats), 32'd18);
    cyc3(0, 0);
    chk3("b2b idle", 0, 16'h0, 0, 0, 0, 1);

    // ---- load while busy: held from beat 3, accepted only on final beat ----
    ld3 = tile_a;
    cyc3(1, 1);
    chk3("busy load", 0, 16'h0, 0, 0, 0, 1);
    for (int k = 0; k < 18; k++) begin
      int b;
      logic [15:0] base;
      b = k % 9;
      base = (k < 9) ? 16'h0000 : 16'h1000;
      if (k == 2) ld3 = tile_b;
      cyc3(k >= 2 && k <= 8, 1);
      chk3($sformatf("busy beat%0d", k), 1, base + 16'(16'h0100 * (b / 3)) + 16'(b % 3),
           b / 3, b % 3, b == 8, b == 8);
    end
    cyc3(0, 0);
    chk3("busy idle", 0, 16'h0, 0, 0, 0, 1);

    // ---- reset mid-drain at beat 4 ----
    ld3 = tile_a;
    cyc3(1, 1);
    for (int k = 0; k < 3; k++) begin
      cyc3(0, 1);
      chk3($sformatf("rst pre beat%0d", k), 1, 16'(k), 0, k, 0, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst async valid", 32'(ov3), 32'h0);
    check("rst async busy", 32'(busy3), 32'h0);
    check("rst async last", 32'(olast3), 32'h0);
    check("rst async data", 32'(od3), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc3(0, 1);
    chk3("rst release", 0, 16'h0, 0, 0, 0, 1);
    ld3 = tile_b;
    cyc3(1, 1);
    chk3("rst reload", 0, 16'h0, 0, 0, 0, 1);
    for (int b = 0; b < 9; b++) begin
      cyc3(0, 1);
      chk3($sformatf("rst post beat%0d", b), 1, 16'h1000 + 16'(16'h0100 * (b / 3)) + 16'(b % 3),
           b / 3, b % 3, b == 8, b == 8);
    end
    cyc3(0, 0);

    // ---- BLOCK_SIZE = 5: 25 beats, column wraps at 4 ----
    t = mk_tile(5, 16'h0000);
    ld5 = t;
    @(posedge clk); #1; lv5 = 1; ordy5 = 1; @(negedge clk);
    check("bs5 load_ready", 32'(lr5), 32'h1);
    for (int b = 0; b < 25; b++) begin
      @(posedge clk); #1; lv5 = 0; @(negedge clk);
      check($sformatf("bs5 beat%0d valid", b), 32'(ov5), 32'h1);
      check($sformatf("bs5 beat%0d data", b), 32'(od5), 32'(16'h0100 * (b / 5) + b % 5));
      check($sformatf("bs5 beat%0d row", b), 32'(orow5), 32'(b / 5));
      check($sformatf("bs5 beat%0d col", b), 32'(ocol5), 32'(b % 5));
      check($sformatf("bs5 beat%0d last", b), 32'(olast5), 32'(b == 24));
    end
    @(posedge clk); #1; ordy5 = 0; @(negedge clk);
    check("bs5 idle valid", 32'(ov5), 32'h0);
    check("bs5 idle load_ready", 32'(lr5), 32'h1);

    // ---- BLOCK_SIZE = 2: 4 beats, last on (1,1) ----
    t = mk_tile(2, 16'h0000);
    ld2 = t[63:0];
    @(posedge clk); #1; lv2 = 1; ordy2 = 1; @(negedge clk);
    check("bs2 load_ready", 32'(lr2), 32'h1);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1; lv2 = 0; @(negedge clk);
      check($sformatf("bs2 beat%0d valid", b), 32'(ov2), 32'h1);
      check($sformatf("bs2 beat%0d data", b), 32'(od2), 32'(16'h0100 * (b / 2) + b % 2));
      check($sformatf("bs2 beat%0d row", b), 32'(orow2), 32'(b / 2));
      check($sformatf("bs2 beat%0d col", b), 32'(ocol2), 32'(b % 2));
      check($sformatf("bs2 beat%0d last", b), 32'(olast2), 32'(b == 3));
    end
    @(posedge clk); #1; ordy2 = 0; @(negedge clk);
    check("bs2 idle valid", 32'(ov2), 32'h0);
    check("bs2 idle load_ready", 32'(lr2), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
